ahb_bram_ctrl: RTL and testbench

//  AHB-Lite slave that sequences the dual-port program/data Block RAM of the Cortex-M0 SoC.
//  - Zero-wait-state reads and writes, with byte-lane strobes.
//  - Read-after-write forwarding for same-cycle collisions.
//  - Arbitrates port A between the AHB write path and a streaming image loader (UART boot download).

---
 rtl/ahb_bram_ctrl_pkg.sv | 39 +++
 rtl/ahb_bram_loader.sv | 78 +++++++
 rtl/ahb_bram_ctrl.sv | 125 ++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bram_ctrl_pkg.sv
// ahb_bram_ctrl_pkg
//   Shared definitions for the AHB-Lite Block RAM controller:
//   HSIZE codes, loader FSM state encoding, byte-strobe decode
//   and per-lane merge helpers.
package ahb_bram_ctrl_pkg;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    // Sizes above half-word (including the illegal >2 codes) write the whole word.
    function automatic logic [3:0] byte_strobe(input logic [2:0] hsize,
                                               input logic [1:0] lo);
        logic [3:0] strb;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << lo;
            HSIZE_HALF: strb = lo[1] ? 4'b1100 : 4'b0011;
            default:    strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Byte lanes with sel set come from fwd, the rest from mem.
    function automatic logic [31:0] lane_merge(input logic [31:0] fwd,
                                               input logic [31:0] mem,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? fwd[8*i +: 8] : mem[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb_bram_loader.sv
// ahb_bram_loader
//   Streaming image loader: walks ld_len words starting at ld_base and
//   requests full-word port-A writes, yielding to AHB write data phases.
// Ports
//   clka, rst        clock, synchronous active-high reset
//   ld_start/base/len start pulse, first word address, word count
//   ld_valid          loader word valid
//   ahb_wr_dphase     AHB write owns port A this cycle
//   ld_ready          word accepted (also the port-A write request)
//   ld_busy, ld_done  load in progress, one-cycle completion pulse
//   ld_addr           word address for the accepted word
module ahb_bram_loader
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH-1:0] ld_base,
    input  logic [ADDR_WIDTH:0]   ld_len,
    input  logic                  ld_valid,
    input  logic                  ahb_wr_dphase,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done,
    output logic [ADDR_WIDTH-1:0] ld_addr
);

    ld_state_e             state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic                  accept;

    assign accept  = (state == LD_LOAD) & ld_valid & ~ahb_wr_dphase;
    assign ld_addr = addr_q;

    always_ff @(posedge clka) begin
        if (rst) begin
            state  <= LD_IDLE;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == LD_IDLE && ld_start) begin
                addr_q <= ld_base;
                cnt_q  <= ld_len;
            end else if (accept) begin
                addr_q <= addr_q + 1'b1;   // wraps modulo the BRAM depth
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

    // Outputs are masked during the reset cycle so a stale LOAD state cannot write.
    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        ld_busy  = 1'b0;
        ld_done  = 1'b0;
        case (state)
            LD_IDLE: begin
                if (ld_start) state_nx = (ld_len == '0) ? LD_DONE : LD_LOAD;
            end
            LD_LOAD: begin
                ld_busy  = ~rst;
                ld_ready = ~rst & accept;
                if (accept && cnt_q == (ADDR_WIDTH+1)'(1)) state_nx = LD_DONE;
            end
            LD_DONE: begin
                ld_done  = ~rst;
                state_nx = LD_IDLE;
            end
            default: state_nx = LD_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl
//   Zero-wait-state AHB-Lite slave for the dual-port program/data BRAM.
//   Port A carries writes (AHB data phase first, loader otherwise),
//   port B carries reads; same-cycle write/read collisions are forwarded.
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   HSEL..HWDATA            AHB-Lite slave inputs
//   HREADYOUT, HRESP, HRDATA AHB-Lite slave outputs
//   bram_addra/dina/wea     BRAM port A (write)
//   bram_addrb, bram_doutb  BRAM port B (registered read, 1-cycle latency)
//   ld_*                    streaming image loader handshake
module ahb_bram_ctrl
    import ahb_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic                  HREADY,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] bram_addra,
    output logic [31:0]           bram_dina,
    output logic [3:0]            bram_wea,
    output logic [ADDR_WIDTH-1:0] bram_addrb,
    input  logic [31:0]           bram_doutb,
    input  logic                  ld_start,
    input  logic [ADDR_WIDTH-1:0] ld_base,
    input  logic [ADDR_WIDTH:0]   ld_len,
    input  logic                  ld_valid,
    input  logic [31:0]           ld_data,
    output logic                  ld_ready,
    output logic                  ld_busy,
    output logic                  ld_done
);

    logic                  acc;
    logic [ADDR_WIDTH-1:0] haddr_w;
    logic                  unused_bits;

    logic                  wr_pend_p0;
    logic [ADDR_WIDTH-1:0] wr_addr_p0;
    logic [3:0]            wr_strb_p0;
    logic                  rd_pend_p0;
    logic [31:0]           fwd_data_p0;
    logic [3:0]            fwd_strb_p0;

    logic [ADDR_WIDTH-1:0] porta_addr;
    logic [31:0]           porta_din;
    logic [3:0]            porta_we;
    logic [ADDR_WIDTH-1:0] ld_addr;

    assign acc         = HSEL & HREADY & HTRANS[1];
    assign haddr_w     = HADDR[ADDR_WIDTH+1:2];
    assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    ahb_bram_loader #(.ADDR_WIDTH(ADDR_WIDTH)) u_loader (
        .clka          (HCLK),
        .rst           (HRESET),
        .ld_start      (ld_start),
        .ld_base       (ld_base),
        .ld_len        (ld_len),
        .ld_valid      (ld_valid),
        .ahb_wr_dphase (wr_pend_p0),
        .ld_ready      (ld_ready),
        .ld_busy       (ld_busy),
        .ld_done       (ld_done),
        .ld_addr       (ld_addr)
    );

    // Port A: an AHB write data phase always wins; the loader fills idle cycles.
    always_comb begin
        porta_addr = '0;
        porta_din  = '0;
        porta_we   = '0;
        if (wr_pend_p0) begin
            porta_addr = wr_addr_p0;
            porta_din  = HWDATA;
            porta_we   = wr_strb_p0;
        end else if (ld_ready) begin
            porta_addr = ld_addr;
            porta_din  = ld_data;
            porta_we   = 4'hF;
        end
    end

    // Stage p0: address phase -> data phase. Forward regs capture a port-A
    // write that lands on the word being read, since port B returns old data.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wr_pend_p0  <= 1'b0;
            wr_addr_p0  <= '0;
            wr_strb_p0  <= '0;
            rd_pend_p0  <= 1'b0;
            fwd_data_p0 <= '0;
            fwd_strb_p0 <= '0;
        end else begin
            wr_pend_p0  <= acc & HWRITE;
            wr_addr_p0  <= haddr_w;
            wr_strb_p0  <= byte_strobe(HSIZE, HADDR[1:0]);
            rd_pend_p0  <= acc & ~HWRITE;
            fwd_data_p0 <= porta_din;
            fwd_strb_p0 <= (acc && !HWRITE && porta_addr == haddr_w) ? porta_we : 4'h0;
        end
    end

    // Everything facing the BRAM and the bus is held at zero during reset.
    assign bram_addra = HRESET ? '0 : porta_addr;
    assign bram_dina  = HRESET ? '0 : porta_din;
    assign bram_wea   = HRESET ? '0 : porta_we;
    assign bram_addrb = HRESET ? '0 : haddr_w;
    assign HRDATA     = (rd_pend_p0 && !HRESET)
                        ? lane_merge(fwd_data_p0, bram_doutb, fwd_strb_p0) : 32'h0;

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
module tb_ahb_bram_ctrl;

    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic          HREADY;
    logic [31:0]   HWDATA;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] bram_addra;
    logic [31:0]   bram_dina;
    logic [3:0]    bram_wea;
    logic [AW-1:0] bram_addrb;
    logic [31:0]   bram_doutb;
    logic          ld_start;
    logic [AW-1:0] ld_base;
    logic [AW:0]   ld_len;
    logic          ld_valid;
    logic [31:0]   ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;

    int n_cmp = 0;
    int n_bad = 0;
    int w0;
    logic clr;
    logic [31:0] mem [0:4095];
    int wr_cnt;

    always #5 HCLK = ~HCLK;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .bram_addra(bram_addra), .bram_dina(bram_dina), .bram_wea(bram_wea),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
    );

    function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Read-first dual-port BRAM model with a write counter.
    always @(posedge HCLK) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            wr_cnt <= 0;
        end else if (|bram_wea) begin
            mem[bram_addra] <= wmerge(mem[bram_addra], bram_dina, bram_wea);
            wr_cnt <= wr_cnt + 1;
        end
        bram_doutb <= mem[bram_addrb];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #2;
    endtask

    task automatic ahb(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a; HSIZE = sz;
    endtask

    task automatic ahb_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1; clr = 1'b1; HREADY = 1'b1; HWDATA = 32'h0;
        ahb_idle(); HADDR = 32'h0;
        ld_start = 1'b0; ld_base = '0; ld_len = '0; ld_valid = 1'b0; ld_data = 32'h0;
        repeat (3) cyc();

        // Reset state, with a read request on the bus that must stay invisible
        ahb(0, 32'h40, 3'd2);
        #1;
        chk("rst_hreadyout", HREADYOUT, 32'h1);
        chk("rst_hresp", HRESP, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_wea", bram_wea, 32'h0);
        chk("rst_addrb", bram_addrb, 32'h0);
        chk("rst_busy", ld_busy, 32'h0);
        chk("rst_done", ld_done, 32'h0);
        chk("rst_ready", ld_ready, 32'h0);
        ahb_idle(); HRESET = 1'b0; clr = 1'b0;
        cyc();

        // T1: word write then read
        ahb(1, 32'h10, 3'd2); #1;
        chk("t1_hreadyout", HREADYOUT, 32'h1);
        cyc();
        ahb_idle(); HWDATA = 32'hDEADBEEF; #1;
        chk("t1_wea", bram_wea, 32'hF);
        chk("t1_addra", bram_addra, 32'h4);
        chk("t1_dina", bram_dina, 32'hDEADBEEF);
        cyc();
        ahb(0, 32'h10, 3'd2); HWDATA = 32'h0; #1;
        chk("t1_addrb", bram_addrb, 32'h4);
        chk("t1_wea_rd", bram_wea, 32'h0);
        cyc();
        ahb_idle(); #1;
        chk("t1_hrdata", HRDATA, 32'hDEADBEEF);
        cyc(); #1;
        chk("t1_hrdata_idle", HRDATA, 32'h0);

        // T2: byte write over a word, plus strobe decode variants
        ahb(1, 32'h10, 3'd2); cyc();
        ahb(1, 32'h13, 3'd0); HWDATA = 32'h11223344; cyc();
        ahb_idle(); HWDATA = 32'hAA000000; #1;
        chk("t2_wea_byte3", bram_wea, 32'h8);
        cyc();
        ahb(0, 32'h10, 3'd2); cyc();
        ahb_idle(); #1;
        chk("t2_hrdata", HRDATA, 32'hAA223344);
        cyc();
        ahb(1, 32'h16, 3'd1); cyc();
        ahb(1, 32'h19, 3'd0); HWDATA = 32'h0; #1;
        chk("t2_wea_half_hi", bram_wea, 32'hC);
        chk("t2_addra_half", bram_addra, 32'h5);
        cyc();
        ahb(1, 32'h1B, 3'd3); #1;
        chk("t2_wea_byte1", bram_wea, 32'h2);
        cyc();
        ahb_idle(); #1;
        chk("t2_wea_size3", bram_wea, 32'hF);
        chk("t2_addra_size3", bram_addra, 32'h6);
        cyc();

        // T3: same-cycle write/read collision, full and partial
        ahb(1, 32'h20, 3'd2); cyc();
        ahb(0, 32'h20, 3'd2); HWDATA = 32'h12345678; cyc();
        ahb_idle(); HWDATA = 32'h0; #1;
        chk("t3_fwd_full", HRDATA, 32'h12345678);
        cyc();
        ahb(1, 32'h21, 3'd0); cyc();
        ahb(0, 32'h20, 3'd2); HWDATA = 32'h00005500; cyc();
        ahb_idle(); HWDATA = 32'h0; #1;
        chk("t3_fwd_lane1", HRDATA, 32'h12345578);
        cyc();

        // T4: loader wraps around the top of the address space
        w0 = wr_cnt;
        ld_base = 12'hFFE; ld_len = 13'd4; ld_start = 1'b1; ld_valid = 1'b1;
        ld_data = 32'hA0000000; #1;
        chk("t4_ready_idle", ld_ready, 32'h0);
        cyc();
        ld_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ea;
            ea = (32'hFFE + k) & 32'hFFF;
            ld_data = 32'hA0000000 + k; #1;
            chk("t4_busy", ld_busy, 32'h1);
            chk("t4_ready", ld_ready, 32'h1);
            chk("t4_addra", bram_addra, ea);
            cyc();
        end
        ld_valid = 1'b0; #1;
        chk("t4_done", ld_done, 32'h1);
        chk("t4_busy_fall", ld_busy, 32'h0);
        cyc(); #1;
        chk("t4_done_once", ld_done, 32'h0);
        chk("t4_wr_count", wr_cnt - w0, 32'd4);
        chk("t4_mem_ffe", mem[12'hFFE], 32'hA0000000);
        chk("t4_mem_000", mem[12'h000], 32'hA0000002);
        chk("t4_mem_001", mem[12'h001], 32'hA0000003);
        // zero-length load completes immediately
        ld_len = '0; ld_start = 1'b1; cyc();
        ld_start = 1'b0; #1;
        chk("t4_len0_done", ld_done, 32'h1);
        chk("t4_len0_busy", ld_busy, 32'h0);
        cyc(); #1;
        chk("t4_len0_once", ld_done, 32'h0);

        // T5: AHB writes starve the loader during data phases
        w0 = wr_cnt;
        ld_base = 12'h100; ld_len = 13'd3; ld_start = 1'b1; ld_valid = 1'b1;
        ld_data = 32'hB0000000;
        ahb(1, 32'h800, 3'd2); cyc();
        ld_start = 1'b0;
        ahb(1, 32'h804, 3'd2); HWDATA = 32'hC0000000; #1;
        chk("t5_ready_c1", ld_ready, 32'h0);
        chk("t5_busy_c1", ld_busy, 32'h1);
        chk("t5_addra_c1", bram_addra, 32'h200);
        cyc();
        ahb(1, 32'h808, 3'd2); HWDATA = 32'hC0000001; #1;
        chk("t5_ready_c2", ld_ready, 32'h0);
        cyc();
        ahb_idle(); HWDATA = 32'hC0000002; #1;
        chk("t5_ready_c3", ld_ready, 32'h0);
        chk("t5_addra_c3", bram_addra, 32'h202);
        cyc();
        HWDATA = 32'h0;
        for (int k = 0; k < 3; k++) begin
            ld_data = 32'hB0000000 + k; #1;
            chk("t5_ready_ld", ld_ready, 32'h1);
            chk("t5_addra_ld", bram_addra, 32'h100 + k);
            cyc();
        end
        ld_valid = 1'b0; #1;
        chk("t5_done", ld_done, 32'h1);
        cyc();
        chk("t5_wr_count", wr_cnt - w0, 32'd6);
        chk("t5_mem_100", mem[12'h100], 32'hB0000000);
        chk("t5_mem_102", mem[12'h102], 32'hB0000002);
        chk("t5_mem_200", mem[12'h200], 32'hC0000000);
        chk("t5_mem_202", mem[12'h202], 32'hC0000002);

        // T6: reset mid-load with an AHB write pending
        w0 = wr_cnt;
        ld_base = 12'h300; ld_len = 13'd5; ld_start = 1'b1; ld_valid = 1'b1;
        ld_data = 32'hD0000000; cyc();
        ld_start = 1'b0; #1;
        chk("t6_ready_w0", ld_ready, 32'h1);
        cyc();
        ld_data = 32'hD0000001; ahb(1, 32'h1000, 3'd2); #1;
        chk("t6_addra_w1", bram_addra, 32'h301);
        cyc();
        HRESET = 1'b1; ahb_idle(); HWDATA = 32'hEEEEEEEE; ld_data = 32'hD0000002; #1;
        chk("t6_rst_wea", bram_wea, 32'h0);
        chk("t6_rst_busy", ld_busy, 32'h0);
        chk("t6_rst_ready", ld_ready, 32'h0);
        cyc();
        HRESET = 1'b0; #1;
        chk("t6_post_wea", bram_wea, 32'h0);
        chk("t6_post_busy", ld_busy, 32'h0);
        chk("t6_post_ready", ld_ready, 32'h0);
        cyc(); cyc();
        chk("t6_wr_count", wr_cnt - w0, 32'd2);
        chk("t6_mem_301", mem[12'h301], 32'hD0000001);
        chk("t6_mem_302", mem[12'h302], 32'h0);
        chk("t6_mem_400", mem[12'h400], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
